// File: rtl/maze_dfs_ctrl.sv
// maze_dfs_ctrl: depth-first maze explorer with a move stack, bounds masking,
// step/overflow guards and a handshaked replay of the found path.
module maze_dfs_ctrl #(
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4,
  parameter int DEPTH     = 256,
  parameter int MAX_STEPS = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ROW_W-1:0]             start_row,
  input  logic [COL_W-1:0]             start_col,
  input  logic [ROW_W-1:0]             goal_row,
  input  logic [COL_W-1:0]             goal_col,
  input  logic [1:0]                   prio_sel,
  input  logic [3:0]                   is_allowed,
  input  logic                         run,
  input  logic                         out_ready,
  output logic [ROW_W-1:0]             row,
  output logic [COL_W-1:0]             col,
  output logic                         mark,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [$clog2(DEPTH):0]       path_len,
  output logic [$clog2(MAX_STEPS):0]   step_count,
  output logic                         out_valid,
  output logic [1:0]                   out_move,
  output logic                         out_last
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_STEPS) + 1;
  localparam logic [AW:0]   SP_FULL  = DEPTH[AW:0];
  localparam logic [SW-1:0] STEP_MAX = MAX_STEPS[SW-1:0];
  typedef enum logic [2:0] {IDLE, INIT, MARK, EXPLORE, BACK, DONE, REPLAY, FAIL} state_t;
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, goal_row_q, goal_row_d;
  logic [COL_W-1:0] col_q, col_d, goal_col_q, goal_col_d;
  logic [AW:0] sp_q, sp_d, rd_q, rd_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [1:0] code_q, code_d, prio_q, prio_d;
  logic [1:0] stack_q [DEPTH];
  logic [3:0] eff;
  logic [7:0] ord;
  logic [1:0] dir, top, mv;
  logic found, push, moving, timeout, at_goal;
  // bit order of eff matches the direction index: UP, RIGHT, LEFT, DOWN
  assign eff = is_allowed & {row_q != '1, col_q != '0, col_q != '1, row_q != '0};
  assign ord = prio_q == 2'd0 ? 8'b11_10_01_00 :
               prio_q == 2'd1 ? 8'b00_01_10_11 :
               prio_q == 2'd2 ? 8'b10_00_11_01 : 8'b01_11_00_10;
  always_comb begin
    found = 1'b0;
    dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eff[ord[2*i +: 2]]) begin
        found = 1'b1;
        dir = ord[2*i +: 2];
      end
    end
  end
  assign top     = stack_q[AW'(sp_q - 1'b1)];
  assign mv      = state_q == BACK ? 2'd3 - top : dir;
  assign timeout = steps_q == STEP_MAX;
  assign at_goal = row_q == goal_row_q && col_q == goal_col_q;
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    sp_d       = sp_q;
    rd_d       = rd_q;
    steps_d    = steps_q;
    code_d     = code_q;
    prio_d     = prio_q;
    goal_row_d = goal_row_q;
    goal_col_d = goal_col_q;
    push       = 1'b0;
    moving     = 1'b0;
    case (state_q)
      IDLE: state_d = start ? INIT : IDLE;
      INIT: begin
        row_d      = start_row;
        col_d      = start_col;
        sp_d       = '0;
        rd_d       = '0;
        steps_d    = '0;
        code_d     = 2'd0;
        prio_d     = prio_sel;
        goal_row_d = goal_row;
        goal_col_d = goal_col;
        state_d    = MARK;
      end
      MARK: begin
        state_d = timeout ? FAIL : EXPLORE;
        code_d  = timeout ? 2'd3 : code_q;
      end
      EXPLORE: begin
        if (timeout) begin
          state_d = FAIL;
          code_d  = 2'd3;
        end else if (at_goal) begin
          state_d = DONE;
        end else if (!found) begin
          state_d = BACK;
        end else if (sp_q == SP_FULL) begin
          state_d = FAIL;
          code_d  = 2'd2;
        end else begin
          push    = 1'b1;
          moving  = 1'b1;
          sp_d    = sp_q + 1'b1;
          steps_d = steps_q + 1'b1;
          state_d = MARK;
        end
      end
      BACK: begin
        if (sp_q == '0) begin
          state_d = FAIL;
          code_d  = 2'd1;
        end else begin
          moving  = 1'b1;
          sp_d    = sp_q - 1'b1;
          steps_d = steps_q + 1'b1;
          state_d = EXPLORE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = INIT;
        end else if (run && sp_q != '0) begin
          state_d = REPLAY;
          rd_d    = '0;
        end
      end
      REPLAY: begin
        if (out_ready) begin
          rd_d    = rd_q + 1'b1;
          state_d = out_last ? DONE : REPLAY;
        end
      end
      FAIL: state_d = start ? INIT : FAIL;
      default: state_d = IDLE;
    endcase
    if (moving) begin
      row_d = mv == 2'd0 ? row_q - 1'b1 : mv == 2'd3 ? row_q + 1'b1 : row_q;
      col_d = mv == 2'd2 ? col_q - 1'b1 : mv == 2'd1 ? col_q + 1'b1 : col_q;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      sp_q       <= '0;
      rd_q       <= '0;
      steps_q    <= '0;
      code_q     <= 2'd0;
      prio_q     <= 2'd0;
      goal_row_q <= '0;
      goal_col_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sp_q       <= sp_d;
      rd_q       <= rd_d;
      steps_q    <= steps_d;
      code_q     <= code_d;
      prio_q     <= prio_d;
      goal_row_q <= goal_row_d;
      goal_col_q <= goal_col_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) stack_q[sp_q[AW-1:0]] <= dir;
  end
  assign row        = row_q;
  assign col        = col_q;
  assign mark       = state_q == MARK;
  assign busy       = state_q inside {INIT, MARK, EXPLORE, BACK};
  assign done       = state_q == DONE;
  assign fail       = state_q == FAIL;
  assign fail_code  = code_q;
  assign path_len   = sp_q;
  assign step_count = steps_q;
  assign out_valid  = state_q == REPLAY;
  assign out_move   = stack_q[rd_q[AW-1:0]];
  assign out_last   = state_q == REPLAY && rd_q == sp_q - 1'b1;
endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// tb_maze_dfs_ctrl: directed search vectors over three parameterisations plus
// replay, stall, start/run corner and mid-replay reset sequences.
module tb_maze_dfs_ctrl;
  localparam int OPEN = 0, WALLED = 1, CORR = 2, DEAD = 3, TEE = 4;
  typedef struct {
    int sel, sc, sr, scol, gr, gc, prio;
    int done, code, pl, steps, r, c;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] start_v = '0;
  logic [3:0] start_row = '0, start_col = '0, goal_row = '0, goal_col = '0;
  logic [1:0] prio_sel = '0;
  logic [3:0] is_allowed;
  logic run = 1'b0, out_ready = 1'b0;
  logic [3:0] row_v [3];
  logic [3:0] col_v [3];
  logic [1:0] fc_v [3];
  logic [1:0] mv_v [3];
  logic [2:0] mark_v, busy_v, done_v, fail_v, ov_v, ol_v;
  logic [8:0] pl0, pl2;
  logic [2:0] pl1;
  logic [12:0] sc0, sc1;
  logic [3:0] sc2;
  int sel = 0, scen = OPEN;
  int cur_pl, cur_sc;
  logic clr = 1'b0;
  logic [255:0] visited = '0;
  int n_tests = 0, n_fail = 0;
  vec_t v [9];

  always #5 clock = ~clock;

  maze_dfs_ctrl u0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .start_row(start_row), .start_col(start_col),
    .goal_row(goal_row), .goal_col(goal_col), .prio_sel(prio_sel), .is_allowed(is_allowed),
    .run(run), .out_ready(out_ready), .row(row_v[0]), .col(col_v[0]), .mark(mark_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]), .fail_code(fc_v[0]), .path_len(pl0),
    .step_count(sc0), .out_valid(ov_v[0]), .out_move(mv_v[0]), .out_last(ol_v[0]));
  maze_dfs_ctrl #(.DEPTH(4)) u1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .start_row(start_row), .start_col(start_col),
    .goal_row(goal_row), .goal_col(goal_col), .prio_sel(prio_sel), .is_allowed(is_allowed),
    .run(run), .out_ready(out_ready), .row(row_v[1]), .col(col_v[1]), .mark(mark_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]), .fail_code(fc_v[1]), .path_len(pl1),
    .step_count(sc1), .out_valid(ov_v[1]), .out_move(mv_v[1]), .out_last(ol_v[1]));
  maze_dfs_ctrl #(.MAX_STEPS(8)) u2 (
    .clock(clock), .reset(reset), .start(start_v[2]), .start_row(start_row), .start_col(start_col),
    .goal_row(goal_row), .goal_col(goal_col), .prio_sel(prio_sel), .is_allowed(is_allowed),
    .run(run), .out_ready(out_ready), .row(row_v[2]), .col(col_v[2]), .mark(mark_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .fail(fail_v[2]), .fail_code(fc_v[2]), .path_len(pl2),
    .step_count(sc2), .out_valid(ov_v[2]), .out_move(mv_v[2]), .out_last(ol_v[2]));

  // Out-of-range neighbours wrap here on purpose, so the DUT's bounds mask is exercised.
  function automatic logic ok(input int sc, input logic [255:0] vis, input logic [3:0] r, input logic [3:0] c);
    logic open;
    open = sc == OPEN ? 1'b1 :
           sc == CORR ? r == 4'd0 :
           sc == DEAD ? (r == 4'd0 && c <= 4'd5) :
           sc == TEE  ? ((r == 4'd0 && c <= 4'd5) || c == 4'd0) : 1'b0;
    return open && !vis[{r, c}];
  endfunction

  assign is_allowed = {ok(scen, visited, row_v[sel] + 4'd1, col_v[sel]),
                       ok(scen, visited, row_v[sel], col_v[sel] - 4'd1),
                       ok(scen, visited, row_v[sel], col_v[sel] + 4'd1),
                       ok(scen, visited, row_v[sel] - 4'd1, col_v[sel])};

  always_comb begin
    cur_pl = sel == 0 ? int'(pl0) : sel == 1 ? int'(pl1) : int'(pl2);
    cur_sc = sel == 0 ? int'(sc0) : sel == 1 ? int'(sc1) : int'(sc2);
  end

  always @(posedge clock) begin
    if (clr) visited <= '0;
    else if (mark_v[sel]) visited[{row_v[sel], col_v[sel]}] <= 1'b1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setup(input int s, input int sc, input int r0, input int c0, input int r1, input int c1, input int p);
    sel = s;
    scen = sc;
    start_row = 4'(r0);
    start_col = 4'(c0);
    goal_row = 4'(r1);
    goal_col = 4'(c1);
    prio_sel = 2'(p);
  endtask

  task automatic go();
    clr = 1'b1;
    step();
    clr = 1'b0;
    start_v[sel] = 1'b1;
    step();
    start_v = '0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done_v[sel] || fail_v[sel]) && n < 3000) begin
      step();
      n++;
    end
    chk("finish", int'(done_v[sel] | fail_v[sel]), 1);
  endtask

  // Path under test is 15 RIGHT then 15 DOWN.
  task automatic replay(input string tag, input bit toggle, input bit hold);
    int idx = 0;
    int cyc = 0;
    run = 1'b1;
    step();
    run = 1'b0;
    if (hold) start_v[0] = 1'b1;
    while (idx < 30 && cyc < 200) begin
      out_ready = !toggle || (cyc % 2 == 0);
      chk({tag, "_valid"}, int'(ov_v[0]), 1);
      chk({tag, "_move"}, int'(mv_v[0]), idx < 15 ? 1 : 3);
      chk({tag, "_last"}, int'(ol_v[0]), int'(idx == 29));
      if (out_ready) idx++;
      step();
      cyc++;
    end
    start_v = '0;
    out_ready = 1'b0;
    chk({tag, "_done_after"}, int'(done_v[0]), 1);
    chk({tag, "_valid_after"}, int'(ov_v[0]), 0);
    chk({tag, "_path_len"}, int'(pl0), 30);
  endtask

  initial begin
    v[0] = '{0, OPEN,   0,  0, 15, 15, 2, 1, 0,  30,  30, 15, 15};
    v[1] = '{0, OPEN,   0,  0, 15, 15, 0, 1, 0, 240, 240, 15, 15};
    v[2] = '{0, OPEN,   0,  0, 15, 15, 1, 1, 0,  30,  30, 15, 15};
    v[3] = '{0, OPEN,  15, 15,  0,  0, 3, 1, 0,  30,  30,  0,  0};
    v[4] = '{0, OPEN,   3,  3,  3,  3, 0, 1, 0,   0,   0,  3,  3};
    v[5] = '{0, WALLED, 0,  0,  5,  5, 0, 0, 1,   0,   0,  0,  0};
    v[6] = '{0, TEE,    0,  0,  4,  0, 0, 1, 0,   4,  14,  4,  0};
    v[7] = '{1, CORR,   0,  0,  0, 10, 0, 0, 2,   4,   4,  0,  4};
    v[8] = '{2, DEAD,   0,  0,  5,  5, 0, 0, 3,   2,   8,  0,  2};

    step();
    step();
    chk("rst_busy", int'(busy_v), 0);
    chk("rst_done", int'(done_v), 0);
    chk("rst_fail", int'(fail_v), 0);
    chk("rst_mark", int'(mark_v), 0);
    chk("rst_valid", int'(ov_v), 0);
    chk("rst_row", int'(row_v[0]), 0);
    chk("rst_col", int'(col_v[0]), 0);
    chk("rst_path_len", int'(pl0), 0);
    chk("rst_steps", int'(sc0), 0);
    chk("rst_code", int'(fc_v[0]), 0);
    reset = 1'b0;

    // walled origin: INIT, MARK, EXPLORE, BACK, then FAIL
    setup(0, WALLED, 0, 0, 5, 5, 0);
    go();
    chk("init_busy", int'(busy_v[0]), 1);
    begin
      int n = 0;
      while (!fail_v[0] && n < 20) begin
        step();
        n++;
      end
      chk("fail_latency", n, 4);
    end
    chk("walled_code", int'(fc_v[0]), 1);
    chk("walled_busy", int'(busy_v[0]), 0);

    for (int i = 0; i < 9; i++) begin
      setup(v[i].sel, v[i].sc, v[i].sr, v[i].scol, v[i].gr, v[i].gc, v[i].prio);
      go();
      wait_end();
      chk($sformatf("v%0d_done", i), int'(done_v[sel]), v[i].done);
      chk($sformatf("v%0d_fail", i), int'(fail_v[sel]), int'(v[i].code != 0));
      chk($sformatf("v%0d_code", i), int'(fc_v[sel]), v[i].code);
      chk($sformatf("v%0d_path_len", i), cur_pl, v[i].pl);
      chk($sformatf("v%0d_steps", i), cur_sc, v[i].steps);
      chk($sformatf("v%0d_row", i), int'(row_v[sel]), v[i].r);
      chk($sformatf("v%0d_col", i), int'(col_v[sel]), v[i].c);
    end

    // run with an empty stack stays in DONE with no stream
    setup(0, OPEN, 3, 3, 3, 3, 0);
    go();
    wait_end();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_run_valid", int'(ov_v[0]), 0);
      chk("empty_run_done", int'(done_v[0]), 1);
    end
    run = 1'b0;

    setup(0, OPEN, 0, 0, 15, 15, 2);
    go();
    wait_end();
    replay("rep", 1'b0, 1'b0);
    replay("rep_hold_start", 1'b0, 1'b1);
    replay("rep_toggle", 1'b1, 1'b0);

    // reset on the second beat while stalled
    run = 1'b1;
    step();
    run = 1'b0;
    out_ready = 1'b1;
    chk("mid_valid0", int'(ov_v[0]), 1);
    chk("mid_move0", int'(mv_v[0]), 1);
    step();
    out_ready = 1'b0;
    chk("mid_valid1", int'(ov_v[0]), 1);
    chk("mid_move1", int'(mv_v[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_rst_valid", int'(ov_v[0]), 0);
    chk("post_rst_done", int'(done_v[0]), 0);
    chk("post_rst_busy", int'(busy_v[0]), 0);
    chk("post_rst_path_len", int'(pl0), 0);
    chk("post_rst_steps", int'(sc0), 0);
    chk("post_rst_row", int'(row_v[0]), 0);
    chk("post_rst_col", int'(col_v[0]), 0);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("idle_run_valid", int'(ov_v[0]), 0);
    chk("idle_run_busy", int'(busy_v[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within 1000000 time units");
    $fatal(1, "watchdog");
  end
endmodule
